// File: rtl/wm_program_controller.sv
// Washing-machine sequencer with an internal phase timer and watchdog.
// Handles hot/cold programs, N rinses, lid pause, spin retry and faults.
// Ports: clock, reset (sync, active-high); sig_* user/sensor inputs;
//   prog_Hot, rinse_Count program selection; state code and actuator
//   outputs (water_Intake, heater_On, motor_Wash, motor_Spin),
//   coin_Return pulse, fault and done flags.
module wm_program_controller #(
  parameter int CNT_W          = 16,
  parameter int FILL_CYCLES    = 8,
  parameter int HEAT_CYCLES    = 8,
  parameter int WASH_CYCLES    = 16,
  parameter int RINSE_CYCLES   = 8,
  parameter int SPIN_CYCLES    = 8,
  parameter int RC_W           = 2,
  parameter int MAX_SPIN_RETRY = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sig_Coin,
  input  logic            sig_Lid_Closed,
  input  logic            sig_Cancel,
  input  logic            sig_Out_Of_Balance,
  input  logic            sig_Motor_Failure,
  input  logic            sig_Fault_Clear,
  input  logic            prog_Hot,
  input  logic [RC_W-1:0] rinse_Count,
  output logic [3:0]      state,
  output logic            water_Intake,
  output logic            heater_On,
  output logic            motor_Wash,
  output logic            motor_Spin,
  output logic            coin_Return,
  output logic            fault,
  output logic            done
);
  localparam int RT_W = $clog2(MAX_SPIN_RETRY + 2);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    READY = 4'd1,
    FILL  = 4'd2,
    HEAT  = 4'd3,
    WASH  = 4'd4,
    RINSE = 4'd5,
    SPIN  = 4'd6,
    DONE  = 4'd7,
    FAULT = 4'd8
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic [RC_W-1:0]  rinse_q, rinse_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic             hot_q, hot_d;
  logic             coin_ret_q, coin_ret_d;
  logic             in_phase, motor_ph, paused;

  always_comb begin
    in_phase = (state_q == FILL) || (state_q == HEAT) ||
               (state_q == WASH) || (state_q == RINSE) ||
               (state_q == SPIN);
    motor_ph = (state_q == WASH) || (state_q == RINSE) ||
               (state_q == SPIN);
    paused   = in_phase && !sig_Lid_Closed;
    wdog_inc = wdog_q + CNT_W'(1);

    state_d    = state_q;
    tmr_d      = tmr_q;
    wdog_d     = in_phase ? wdog_inc : '0;
    retry_d    = retry_q;
    rinse_d    = rinse_q;
    rc_d       = rc_q;
    hot_d      = hot_q;
    coin_ret_d = 1'b0;

    case (state_q)
      IDLE: if (sig_Coin) state_d = READY;
      READY: begin
        if (sig_Cancel) begin
          state_d    = IDLE;
          coin_ret_d = 1'b1;
        end else if (sig_Lid_Closed) begin
          state_d = FILL;
          hot_d   = prog_Hot;
          rc_d    = rinse_Count;
        end
      end
      FILL, HEAT, WASH, RINSE, SPIN: begin
        if (motor_ph && sig_Motor_Failure) begin
          state_d = FAULT;
        end else if (wdog_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          state_d = FAULT;
        end else if (sig_Cancel) begin
          state_d = IDLE;
        end else if (!paused) begin
          if (state_q == SPIN && sig_Out_Of_Balance) begin
            if (retry_q == RT_W'(MAX_SPIN_RETRY)) begin
              state_d = FAULT;
            end else begin
              tmr_d   = CNT_W'(SPIN_CYCLES - 1);
              retry_d = retry_q + RT_W'(1);
            end
          end else if (tmr_q != '0) begin
            tmr_d = tmr_q - CNT_W'(1);
          end else begin
            case (state_q)
              FILL: state_d = hot_q ? HEAT : WASH;
              HEAT: state_d = WASH;
              WASH: begin
                state_d = (rc_q == '0) ? SPIN : RINSE;
                rinse_d = rc_q - RC_W'(1);
              end
              RINSE: begin
                if (rinse_q == '0) begin
                  state_d = SPIN;
                end else begin
                  // next rinse pass: fresh timer and watchdog
                  tmr_d   = CNT_W'(RINSE_CYCLES - 1);
                  wdog_d  = '0;
                  rinse_d = rinse_q - RC_W'(1);
                end
              end
              SPIN:    state_d = DONE;
              default: state_d = IDLE;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      FAULT:   if (sig_Fault_Clear) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // phase entry loads the timer and clears the watchdog
    if (state_d != state_q) begin
      wdog_d = '0;
      case (state_d)
        FILL:  tmr_d = CNT_W'(FILL_CYCLES - 1);
        HEAT:  tmr_d = CNT_W'(HEAT_CYCLES - 1);
        WASH:  tmr_d = CNT_W'(WASH_CYCLES - 1);
        RINSE: tmr_d = CNT_W'(RINSE_CYCLES - 1);
        SPIN: begin
          tmr_d   = CNT_W'(SPIN_CYCLES - 1);
          retry_d = '0;
        end
        default: tmr_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      wdog_q     <= '0;
      retry_q    <= '0;
      rinse_q    <= '0;
      rc_q       <= '0;
      hot_q      <= 1'b0;
      coin_ret_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      wdog_q     <= wdog_d;
      retry_q    <= retry_d;
      rinse_q    <= rinse_d;
      rc_q       <= rc_d;
      hot_q      <= hot_d;
      coin_ret_q <= coin_ret_d;
    end
  end

  // open lid gates every actuator immediately
  always_comb begin
    state        = state_q;
    water_Intake = (state_q == FILL) && sig_Lid_Closed;
    heater_On    = (state_q == HEAT) && sig_Lid_Closed;
    motor_Wash   = ((state_q == WASH) || (state_q == RINSE)) &&
                   sig_Lid_Closed;
    motor_Spin   = (state_q == SPIN) && sig_Lid_Closed;
    coin_Return  = coin_ret_q;
    fault        = (state_q == FAULT);
    done         = (state_q == DONE);
  end

endmodule

// File: tb/tb_wm_program_controller.sv
// Bench for wm_program_controller: directed scenarios plus random
// stimulus, checked every cycle against a behavioural model.
module tb_wm_program_controller;
  localparam int FILLC = 4;
  localparam int HEATC = 3;
  localparam int WASHC = 5;
  localparam int RINC  = 2;
  localparam int SPINC = 3;
  localparam int MAXR  = 2;
  localparam int TO    = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       sig_Coin, sig_Lid_Closed, sig_Cancel;
  logic       sig_Out_Of_Balance, sig_Motor_Failure;
  logic       sig_Fault_Clear, prog_Hot;
  logic [1:0] rinse_Count;
  logic [3:0] state;
  logic       water_Intake, heater_On, motor_Wash, motor_Spin;
  logic       coin_Return, fault, done;

  always #5 clk = ~clk;

  wm_program_controller #(
    .CNT_W(16), .FILL_CYCLES(FILLC), .HEAT_CYCLES(HEATC),
    .WASH_CYCLES(WASHC), .RINSE_CYCLES(RINC), .SPIN_CYCLES(SPINC),
    .RC_W(2), .MAX_SPIN_RETRY(MAXR), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clk), .reset(reset),
    .sig_Coin(sig_Coin), .sig_Lid_Closed(sig_Lid_Closed),
    .sig_Cancel(sig_Cancel), .sig_Out_Of_Balance(sig_Out_Of_Balance),
    .sig_Motor_Failure(sig_Motor_Failure),
    .sig_Fault_Clear(sig_Fault_Clear), .prog_Hot(prog_Hot),
    .rinse_Count(rinse_Count), .state(state),
    .water_Intake(water_Intake), .heater_On(heater_On),
    .motor_Wash(motor_Wash), .motor_Spin(motor_Spin),
    .coin_Return(coin_Return), .fault(fault), .done(done)
  );

  int vecs = 0;
  int errs = 0;

  // behavioural model: cycles left in phase, cycles spent in phase
  int m_st, m_left, m_age, m_retry, m_rinses, m_rc;
  bit m_hot, m_cr;

  int h_st[$];
  int h_cr[$];
  int h_ht[$];
  int h_wm[$];

  task automatic chk(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int dur(input int s);
    case (s)
      2: return FILLC;
      3: return HEATC;
      4: return WASHC;
      5: return RINC;
      6: return SPINC;
      default: return 0;
    endcase
  endfunction

  task automatic enter(input int s);
    m_st  = s;
    m_age = 0;
    m_left = dur(s);
    if (s == 6) m_retry = 0;
  endtask

  task automatic phase_done();
    case (m_st)
      2: enter(m_hot ? 3 : 4);
      3: enter(4);
      4: begin
        m_rinses = 0;
        enter(m_rc == 0 ? 6 : 5);
      end
      5: begin
        m_rinses++;
        if (m_rinses == m_rc) enter(6);
        else begin
          m_left = RINC;
          m_age  = 0;
        end
      end
      6: enter(7);
      default: enter(0);
    endcase
  endtask

  task automatic model_step(input bit c, l, k, o, m, f, h,
                            input int r);
    int age;
    bit ncr;
    ncr = 1'b0;
    case (m_st)
      0: if (c) enter(1);
      1: begin
        if (k) begin
          enter(0);
          ncr = 1'b1;
        end else if (l) begin
          m_hot = h;
          m_rc  = r;
          enter(2);
        end
      end
      2, 3, 4, 5, 6: begin
        age = m_age + 1;
        if (m_st >= 4 && m) enter(8);
        else if (age >= TO) enter(8);
        else if (k) enter(0);
        else begin
          m_age = age;
          if (l) begin
            if (m_st == 6 && o) begin
              if (m_retry == MAXR) enter(8);
              else begin
                m_retry++;
                m_left = SPINC;
              end
            end else begin
              m_left--;
              if (m_left == 0) phase_done();
            end
          end
        end
      end
      7: enter(0);
      8: if (f) enter(0);
      default: enter(0);
    endcase
    m_cr = ncr;
  endtask

  task automatic cyc(input bit c, l, k, o, m, f, h, input int r);
    int act, exp;
    @(negedge clk);
    sig_Coin           = c;
    sig_Lid_Closed     = l;
    sig_Cancel         = k;
    sig_Out_Of_Balance = o;
    sig_Motor_Failure  = m;
    sig_Fault_Clear    = f;
    prog_Hot           = h;
    rinse_Count        = r[1:0];
    #1;
    act = {state, water_Intake, heater_On, motor_Wash, motor_Spin,
           coin_Return, fault, done};
    exp = (m_st << 7) |
          (int'(m_st == 2 && l) << 6) |
          (int'(m_st == 3 && l) << 5) |
          (int'((m_st == 4 || m_st == 5) && l) << 4) |
          (int'(m_st == 6 && l) << 3) |
          (int'(m_cr) << 2) |
          (int'(m_st == 8) << 1) |
          int'(m_st == 7);
    chk("outputs", act, exp);
    h_st.push_back(int'(state));
    h_cr.push_back(int'(coin_Return));
    h_ht.push_back(int'(heater_On));
    h_wm.push_back(int'(motor_Wash));
    model_step(c, l, k, o, m, f, h, r);
  endtask

  function automatic int cnt_st(input int s);
    int n = 0;
    foreach (h_st[i]) if (h_st[i] == s) n++;
    return n;
  endfunction

  function automatic int sum_q(input int q[$]);
    int n = 0;
    foreach (q[i]) n += q[i];
    return n;
  endfunction

  task automatic clr_hist();
    h_st.delete();
    h_cr.delete();
    h_ht.delete();
    h_wm.delete();
  endtask

  initial begin
    reset = 1'b1;
    sig_Coin = 0; sig_Lid_Closed = 0; sig_Cancel = 0;
    sig_Out_Of_Balance = 0; sig_Motor_Failure = 0;
    sig_Fault_Clear = 0; prog_Hot = 0; rinse_Count = 0;
    m_st = 0; m_left = 0; m_age = 0; m_retry = 0;
    m_rinses = 0; m_rc = 0; m_hot = 0; m_cr = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset", {state, water_Intake, heater_On, motor_Wash,
                  motor_Spin, coin_Return, fault, done}, 0);
    model_step(0, 0, 0, 0, 0, 0, 0, 0);

    // hot program, two rinses
    clr_hist();
    for (int i = 0; i < 26; i++) cyc(i == 0, 1, 0, 0, 0, 0, 1, 2);
    chk("hot_fill", cnt_st(2), 4);
    chk("hot_heat", cnt_st(3), 3);
    chk("hot_wash", cnt_st(4), 5);
    chk("hot_rinse", cnt_st(5), 4);
    chk("hot_spin", cnt_st(6), 3);
    chk("hot_done", cnt_st(7), 1);
    chk("hot_done_at", h_st[21], 7);
    chk("hot_idle_after", h_st[22], 0);

    // cold program, no rinse
    clr_hist();
    for (int i = 0; i < 26; i++) cyc(i == 0, 1, 0, 0, 0, 0, 0, 0);
    chk("cold_fill", cnt_st(2), 4);
    chk("cold_heat", cnt_st(3), 0);
    chk("cold_wash", cnt_st(4), 5);
    chk("cold_rinse", cnt_st(5), 0);
    chk("cold_spin", cnt_st(6), 3);
    chk("cold_heater", sum_q(h_ht), 0);

    // lid opened three cycles mid-wash
    clr_hist();
    for (int i = 0; i < 20; i++)
      cyc(i == 0, !(i >= 8 && i <= 10), 0, 0, 0, 0, 0, 0);
    chk("pause_wash_len", cnt_st(4), 8);
    chk("pause_wash_on", sum_q(h_wm), 5);
    chk("pause_state", h_st[9], 4);

    // three imbalance pulses in spin
    clr_hist();
    for (int i = 0; i < 20; i++)
      cyc(i == 0, 1, 0, (i == 12 || i == 14 || i == 16), 0,
          i == 18, 0, 0);
    chk("imb_spin_len", cnt_st(6), 6);
    chk("imb_fault_st", h_st[17], 8);
    chk("imb_clear", h_st[19], 0);

    // cancel from READY returns the coin for one cycle
    clr_hist();
    for (int i = 0; i < 5; i++) cyc(i == 0, 0, i == 1, 0, 0, 0, 0, 0);
    chk("cancel_state", h_st[2], 0);
    chk("cancel_cr", h_cr[2], 1);
    chk("cancel_cr_len", sum_q(h_cr), 1);

    // lid held open in FILL trips the watchdog
    clr_hist();
    for (int i = 0; i < 15; i++)
      cyc(i == 0, i < 2, 0, 0, 0, i == 13, 0, 0);
    chk("wdog_fill_len", cnt_st(2), 10);
    chk("wdog_fault", h_st[12], 8);
    chk("wdog_clear", h_st[14], 0);

    // random traffic
    for (int blk = 0; blk < 15; blk++) begin
      int lp;
      lp = (blk % 3 == 2) ? 55 : 92;
      for (int i = 0; i < 200; i++)
        cyc($urandom_range(99) < 30, $urandom_range(99) < lp,
            $urandom_range(99) < 3, $urandom_range(99) < 10,
            $urandom_range(99) < 2, $urandom_range(99) < 20,
            $urandom_range(1) == 1, int'($urandom_range(3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
